// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues req/ack reads for the registered PC and
// presents the result in a one-entry IF/ID buffer with a valid/ready handshake.
module fetch_unit #(
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  output logic [31:0] pc_plus4,
  output logic        pc_advance,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic [1:0]  id_fault
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } state_t;

  localparam logic        TO_EN   = (ACK_TIMEOUT != 0);
  localparam logic [31:0] TO_LAST = ACK_TIMEOUT - 1;

  state_t      state;
  logic [31:0] tcount;
  logic        slot_free;
  logic        timeout_hit;
  logic        mis_load;
  logic        ack_load;
  logic        to_load;

  assign slot_free = !id_valid || id_ready;
  assign pc_plus4  = pc_in + 32'd4;

  always_comb begin
    timeout_hit = TO_EN && (tcount == TO_LAST);
    mis_load    = (state == IDLE) && !flush && slot_free && (pc_in[1:0] != 2'b00);
    ack_load    = (state == WAIT) && !flush && imem_ack;
    to_load     = (state == WAIT) && !flush && !imem_ack && timeout_hit;
    pc_advance  = reset && (mis_load || ack_load || to_load);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      id_valid  <= 1'b0;
      id_instr  <= '0;
      id_pc     <= '0;
      id_pc4    <= '0;
      id_fault  <= '0;
      tcount    <= '0;
    end else begin
      if (id_valid && id_ready)
        id_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (!flush && slot_free) begin
            if (pc_in[1:0] != 2'b00) begin
              id_instr <= NOP_INSTR;
              id_pc    <= pc_in;
              id_pc4   <= pc_in + 32'd4;
              id_fault <= 2'd1;
              id_valid <= 1'b1;
            end else begin
              imem_req  <= 1'b1;
              imem_addr <= pc_in;
              tcount    <= '0;
              state     <= WAIT;
            end
          end
        end

        WAIT: begin
          // Flush wins over both a returning ack and an expiring timeout;
          // without an ack the bus still owes us a response, so park in DROP.
          if (flush) begin
            if (imem_ack) begin
              imem_req <= 1'b0;
              state    <= IDLE;
            end else begin
              state <= DROP;
            end
          end else if (imem_ack) begin
            id_instr <= imem_rdata;
            id_pc    <= imem_addr;
            id_pc4   <= imem_addr + 32'd4;
            id_fault <= 2'd0;
            id_valid <= 1'b1;
            imem_req <= 1'b0;
            state    <= IDLE;
          end else if (timeout_hit) begin
            id_instr <= NOP_INSTR;
            id_pc    <= imem_addr;
            id_pc4   <= imem_addr + 32'd4;
            id_fault <= 2'd2;
            id_valid <= 1'b1;
            imem_req <= 1'b0;
            state    <= IDLE;
          end else begin
            tcount <= tcount + 32'd1;
          end
        end

        DROP: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= IDLE;
          end
        end

        default: begin
          imem_req <= 1'b0;
          state    <= IDLE;
        end
      endcase

      if (flush)
        id_valid <= 1'b0;
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage sitting directly downstream of the PC register. Takes the registered PC and issues a request/acknowledge read to instruction memory. Places the returned word, with its PC and PC+4, into a one-entry IF/ID output buffer using a valid/ready handshake to decode. Drives pc_plus4 and pc_advance back upstream so the PC register loads only when a fetch has actually completed; handles branch flush, misaligned PCs and memory timeout.

Parameters:
ACK_TIMEOUT, 255, max cycles in WAIT before abort with bus error; 0 disables timeout
NOP_INSTR, 32'h00000000, word placed in id_instr on a faulted fetch

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-low reset (reset == 0 resets block)
pc_in  input  32  current PC from PC register
pc_plus4  output  32  combinational pc_in + 4, modulo 2^32, to next-PC logic
pc_advance  output  1  one-cycle pulse: PC register loads next PC at this edge
flush  input  1  branch/jump redirect; kill buffered and in-flight fetch
imem_req  output  1  registered read request, held until ack
imem_addr  output  32  registered word address, stable while imem_req = 1
imem_ack  input  1  read data valid this cycle
imem_rdata  input  32  instruction word, sampled when imem_ack = 1
id_valid  output  1  output buffer holds an instruction
id_ready  input  1  decode accepts buffer this cycle
id_instr  output  32  fetched instruction
id_pc  output  32  address of id_instr
id_pc4  output  32  id_pc + 4
id_fault  output  2  0 none, 1 misaligned PC, 2 bus timeout

Behaviour:
- Reset (reset == 0 at clk edge): state = IDLE; imem_req = 0, imem_addr = 0, id_valid = 0, id_instr = 0, id_pc = 0, id_pc4 = 0, id_fault = 0, timeout counter = 0. pc_advance = 0 while reset == 0. Reset overrides everything, including a mid-WAIT request. imem_req drops at that edge; a later ack is ignored.
- slot_free = !id_valid || id_ready. On id_valid && id_ready, id_valid clears at the edge unless a new entry loads at the same edge.
- States: IDLE, WAIT, DROP.
- IDLE, flush = 1: no issue; stay IDLE.
- IDLE, slot_free, pc_in[1:0] != 0: no memory access. Load id_instr = NOP_INSTR, id_pc = pc_in, id_pc4 = pc_in + 4, id_fault = 1, id_valid = 1. pc_advance = 1 this cycle. Stay IDLE.
- IDLE, slot_free, aligned: imem_req <= 1, imem_addr <= pc_in, counter <= 0, go to WAIT.
- WAIT, imem_ack = 1, flush = 0: load id_instr = imem_rdata, id_pc = imem_addr, id_pc4 = imem_addr + 4, id_fault = 0, id_valid = 1. pc_advance = 1 (combinational, same cycle). imem_req <= 0, go to IDLE.
- WAIT, flush = 1, imem_ack = 1: discard data; pc_advance = 0; imem_req <= 0; go to IDLE.
- WAIT, flush = 1, imem_ack = 0: go to DROP with imem_req held at 1.
- DROP: hold imem_req until ack. On ack, discard data, imem_req <= 0, go to IDLE. Any flush in DROP is ignored. pc_advance = 0.
- WAIT timeout: counter increments each WAIT cycle without ack. When counter == ACK_TIMEOUT - 1 and no ack (ACK_TIMEOUT != 0): imem_req <= 0; load id_instr = NOP_INSTR, id_pc = imem_addr, id_fault = 2, id_valid = 1; pc_advance = 1; go to IDLE.
- flush always clears id_valid at the edge, with priority over a concurrent id_ready acceptance. No new entry loads on a flush cycle.
- Issue is gated by slot_free, so the buffer is guaranteed empty or draining when ack arrives. There is at most one outstanding request.
- Latency: request visible 1 cycle after IDLE issue. Zero-wait ack gives id_valid 2 cycles after issue. Peak throughput is 1 instruction per 2 cycles.
- All +4 arithmetic is 32-bit and wraps: 32'hFFFFFFFC + 4 = 0.

Test Plan:
- Reset release, pc_in = 0x00400000, ack 1 cycle after req, id_ready = 1 -> imem_addr = 0x00400000; id_valid with id_instr = rdata, id_pc4 = 0x00400004; one pc_advance pulse.
- Back-to-back fetch 0x0, 0x4, 0x8 with id_ready = 0 after the first -> second req is not issued until id_ready = 1; no instruction is lost or duplicated.
- flush during WAIT, ack 3 cycles later -> DROP entered; data discarded; no pc_advance; next req uses the new pc_in = 0x00400100.
- flush and imem_ack in the same cycle -> no id_valid, no pc_advance; IDLE on the next cycle.
- pc_in = 0x00400002 -> no imem_req; id_fault = 1, id_instr = 0, pc_advance pulse.
- ACK_TIMEOUT = 4, ack never asserted -> req drops after 4 WAIT cycles; id_fault = 2; id_pc = imem_addr. Separately, reset = 0 mid-WAIT -> all outputs 0 next edge.
